// File: rtl/nios2_debug_jtag_host_if.sv
`default_nettype none
// ============================================================================
// Module      : nios2_debug_jtag_host_if
// Description : Command/response bundle between a debug initiator and the
//               nios2_debug_jtag_host scan sequencer.
//                 cmd_valid/cmd_ready - command handshake
//                 cmd_ir / cmd_dr     - virtual IR value and DR word to shift
//                 rsp_valid           - one-cycle completion pulse
//                 rsp_dr / rsp_ir_out - captured TDO word and sampled IR status
//               modport master : the initiator issuing commands
//               modport slave  : the scan sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface nios2_debug_jtag_host_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_dr,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_dr,
    input  rsp_ir_out
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_dr,
    output cmd_ready,
    output rsp_valid,
    output rsp_dr,
    output rsp_ir_out
  );

endinterface
`default_nettype wire

// File: rtl/nios2_debug_jtag_host.sv
`default_nettype none
// ============================================================================
// Module      : nios2_debug_jtag_host
// Description : Host-side driver for the Nios II debug slave virtual JTAG
//               port (2-bit IR, 38-bit DR). One command = one scan through
//               UIR -> CDR -> SDR (DR_WIDTH periods) -> UDR -> RTI, with a
//               TCK generated by dividing clk.
// Ports       :
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          command/response bundle (slave modport)
//   vji_tck      generated TCK (low first half-period, high second half)
//   vji_tdi      serial data to the slave (LSB of the shift register)
//   vji_tdo      serial data from the slave, sampled on TCK rise in SDR
//   vji_ir_in    virtual IR presented to the slave, held between commands
//   vji_ir_out   slave IR status, sampled on TCK rise in UIR
//   vji_uir/cdr/sdr/udr/rti  one-hot virtual-state indicators
// Parameters  :
//   DR_WIDTH  DR scan length (>= 2)
//   IR_WIDTH  virtual IR width
//   TCK_DIV   clk cycles per TCK half-period, 1..15
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_debug_jtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  wire                 clk,
  input  wire                 reset_n,
  nios2_debug_jtag_host_if.slave bus,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  wire                 vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  wire  [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // r_div counts clk cycles inside one TCK period: 0 .. 2*TCK_DIV-1.
  localparam int c_div_w = $clog2(2 * TCK_DIV);
  localparam int c_cnt_w = $clog2(DR_WIDTH + 1);

  // Last cycle of the low half: the following clk edge raises TCK.
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(TCK_DIV - 1);
  // Last cycle of the period: the following clk edge drops TCK.
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(2 * TCK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(DR_WIDTH - 1);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0]  r_div;
  logic [c_cnt_w-1:0]  r_bit;
  logic [DR_WIDTH-1:0] r_shift;
  logic                r_tdo_s;      // TDO captured at the TCK rise
  logic                r_tck;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic                r_ready;
  logic                r_rsp_valid;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [IR_WIDTH-1:0] r_rsp_ir_out;
  logic                r_uir;
  logic                r_cdr;
  logic                r_sdr;
  logic                r_udr;
  logic                r_rti;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic w_half_end;
  logic w_period_end;
  logic w_bit_last;
  logic w_accept;

  assign w_half_end   = (r_div == c_div_half);
  assign w_period_end = (r_div == c_div_last);
  assign w_bit_last   = (r_bit == c_bit_last);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Every non-idle state advances only at a period end, so
  // each state occupies a whole number of TCK periods.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // cmd_ready is high exactly while idle, so valid alone accepts.
        if (bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_UIR;
        end
      end
      ST_UIR: begin
        if (w_period_end) w_state_next = ST_CDR;
      end
      ST_CDR: begin
        if (w_period_end) w_state_next = ST_SDR;
      end
      ST_SDR: begin
        if (w_period_end && w_bit_last) w_state_next = ST_UDR;
      end
      ST_UDR: begin
        if (w_period_end) w_state_next = ST_RTI;
      end
      ST_RTI: begin
        if (w_period_end) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_tdo_s      <= 1'b0;
      r_tck        <= 1'b0;
      r_ir_in      <= '0;
      r_ready      <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_dr     <= '0;
      r_rsp_ir_out <= '0;
      r_uir        <= 1'b0;
      r_cdr        <= 1'b0;
      r_sdr        <= 1'b0;
      r_udr        <= 1'b0;
      r_rti        <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      // State flags and ready are registered copies of the next state, so
      // they line up exactly with r_state.
      r_ready <= (w_state_next == ST_IDLE);
      r_uir   <= (w_state_next == ST_UIR);
      r_cdr   <= (w_state_next == ST_CDR);
      r_sdr   <= (w_state_next == ST_SDR);
      r_udr   <= (w_state_next == ST_UDR);
      r_rti   <= (w_state_next == ST_RTI);

      if (w_accept) begin
        r_ir_in <= bus.cmd_ir;
        r_shift <= bus.cmd_dr;
        r_bit   <= '0;
        r_div   <= '0;
        r_tck   <= 1'b0;
      end else if (r_state != ST_IDLE) begin
        // TCK phase generation
        if (w_period_end) begin
          r_div <= '0;
          r_tck <= 1'b0;
        end else begin
          r_div <= r_div + 1'b1;
          if (w_half_end) r_tck <= 1'b1;
        end

        // Sampling on the TCK rise
        if (w_half_end) begin
          if (r_state == ST_UIR) r_rsp_ir_out <= vji_ir_out;
          if (r_state == ST_SDR) r_tdo_s      <= vji_tdo;
        end

        // Shift on the TCK fall; the TDO bit sampled mid-period enters the
        // MSB, so after DR_WIDTH periods bit 0 holds the first TDO bit.
        if (w_period_end && (r_state == ST_SDR)) begin
          r_shift <= {r_tdo_s, r_shift[DR_WIDTH-1:1]};
          if (!w_bit_last) r_bit <= r_bit + 1'b1;
        end

        // Scan complete: publish the captured word with the return to idle.
        if (w_period_end && (r_state == ST_RTI)) begin
          r_rsp_dr    <= r_shift;
          r_rsp_valid <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.cmd_ready  = r_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_dr     = r_rsp_dr;
  assign bus.rsp_ir_out = r_rsp_ir_out;

  assign vji_tck   = r_tck;
  assign vji_tdi   = r_shift[0];
  assign vji_ir_in = r_ir_in;
  assign vji_uir   = r_uir;
  assign vji_cdr   = r_cdr;
  assign vji_sdr   = r_sdr;
  assign vji_udr   = r_udr;
  assign vji_rti   = r_rti;

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_jtag_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_debug_jtag_host
// Description : Self-checking bench. DUT0 uses default parameters, DUT1 uses
//               TCK_DIV=1. Each DUT talks to a slave model that returns a
//               preset TDO word bit by bit on TCK rises in SDR and records
//               the TDI bits it receives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_debug_jtag_host;

  localparam int DRW  = 38;
  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // --------------------------------------------------------------------------
  // DUT0 (TCK_DIV = 2)
  // --------------------------------------------------------------------------
  nios2_debug_jtag_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(2)) bus0 ();
  logic       vji_tck0, vji_tdi0, vji_tdo0;
  logic [1:0] vji_ir_in0, vji_ir_out0;
  logic       vji_uir0, vji_cdr0, vji_sdr0, vji_udr0, vji_rti0;

  nios2_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(DIV0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .vji_tck(vji_tck0), .vji_tdi(vji_tdi0), .vji_tdo(vji_tdo0),
    .vji_ir_in(vji_ir_in0), .vji_ir_out(vji_ir_out0),
    .vji_uir(vji_uir0), .vji_cdr(vji_cdr0), .vji_sdr(vji_sdr0),
    .vji_udr(vji_udr0), .vji_rti(vji_rti0)
  );

  // --------------------------------------------------------------------------
  // DUT1 (TCK_DIV = 1)
  // --------------------------------------------------------------------------
  nios2_debug_jtag_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(2)) bus1 ();
  logic       vji_tck1, vji_tdi1, vji_tdo1;
  logic [1:0] vji_ir_in1, vji_ir_out1;
  logic       vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;

  nios2_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(DIV1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1),
    .vji_ir_in(vji_ir_in1), .vji_ir_out(vji_ir_out1),
    .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1),
    .vji_udr(vji_udr1), .vji_rti(vji_rti1)
  );

  // --------------------------------------------------------------------------
  // Slave models: bit k of tdo_word is presented before the k-th SDR TCK
  // rise; the TDI value seen at that rise is recorded as bit k.
  // --------------------------------------------------------------------------
  logic [DRW-1:0] tdo_word0 = '0, tdi_seen0 = '0;
  logic [DRW-1:0] tdo_word1 = '0, tdi_seen1 = '0;
  int sidx0 = 0, sidx1 = 0;

  always @(posedge vji_tck0) begin
    if (vji_cdr0) sidx0 = 0;
    else if (vji_sdr0) begin
      if (sidx0 < DRW) tdi_seen0[sidx0] = vji_tdi0;
      sidx0 = sidx0 + 1;
    end
  end
  assign vji_tdo0 = (sidx0 < DRW) ? tdo_word0[sidx0] : 1'b0;

  always @(posedge vji_tck1) begin
    if (vji_cdr1) sidx1 = 0;
    else if (vji_sdr1) begin
      if (sidx1 < DRW) tdi_seen1[sidx1] = vji_tdi1;
      sidx1 = sidx1 + 1;
    end
  end
  assign vji_tdo1 = (sidx1 < DRW) ? tdo_word1[sidx1] : 1'b0;

  // --------------------------------------------------------------------------
  // Reference timing: cycle k (k=1 is the cycle after acceptance) lies in TCK
  // period (k-1)/(2*div); period 0 is UIR, 1 is CDR, DRW following periods
  // are SDR, then UDR and RTI. Returns {uir,cdr,sdr,udr,rti}.
  // --------------------------------------------------------------------------
  function automatic logic [4:0] exp_flags(input int k, input int div);
    int p, ph;
    p = 2 * div;
    if (k < 1 || k > (DRW + 4) * p) return 5'b00000;
    ph = (k - 1) / p;
    if (ph == 0)       return 5'b10000;
    if (ph == 1)       return 5'b01000;
    if (ph <= DRW + 1) return 5'b00100;
    if (ph == DRW + 2) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic exp_tck(input int k, input int div);
    if (k < 1 || k > (DRW + 4) * 2 * div) return 1'b0;
    return (((k - 1) % (2 * div)) >= div);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {bus0.cmd_ready, bus0.rsp_valid, bus0.rsp_dr, bus0.rsp_ir_out,
                 vji_tck0, vji_tdi0, vji_ir_in0,
                 vji_uir0, vji_cdr0, vji_sdr0, vji_udr0, vji_rti0},
          {1'b1, 50'b0});
  endtask

  // One full scan on DUT0, starting at a negedge with the DUT ready. Returns
  // at the negedge of the rsp_valid cycle (or after the cycle budget).
  task automatic do_scan(input string tag, input logic [1:0] ir, input logic [DRW-1:0] dr,
                         input logic [DRW-1:0] tdo, input logic [1:0] irout,
                         input logic [DRW-1:0] exp_dr, input logic [1:0] exp_ir,
                         input int exp_rv, input bit keep);
    int rv, ferr, terr, herr, ierr, len;
    logic [4:0] fl;
    len  = (DRW + 4) * 2 * DIV0;
    rv   = -1; ferr = 0; terr = 0; herr = 0; ierr = 0;
    tdo_word0   = tdo;
    vji_ir_out0 = irout;
    check({tag, "_ready"}, 64'(bus0.cmd_ready), 64'd1);
    bus0.cmd_ir    = ir;
    bus0.cmd_dr    = dr;
    bus0.cmd_valid = 1'b1;
    for (int k = 1; k <= len + 40 && rv < 0; k++) begin
      @(negedge clk);
      if (!keep) bus0.cmd_valid = 1'b0;
      fl = {vji_uir0, vji_cdr0, vji_sdr0, vji_udr0, vji_rti0};
      if (fl !== exp_flags(k, DIV0))      ferr++;
      if (vji_tck0 !== exp_tck(k, DIV0))  terr++;
      if ($countones(fl) > 1)             herr++;
      if (vji_ir_in0 !== ir)              ierr++;
      if (bus0.rsp_valid === 1'b1) rv = k;
    end
    check({tag, "_flag_cycles_wrong"}, 64'(ferr), 64'd0);
    check({tag, "_tck_cycles_wrong"},  64'(terr), 64'd0);
    check({tag, "_multi_flag_cycles"}, 64'(herr), 64'd0);
    check({tag, "_ir_in_cycles_wrong"}, 64'(ierr), 64'd0);
    check({tag, "_rsp_cycle"},  64'(rv), 64'(exp_rv));
    check({tag, "_rsp_dr"},     64'(bus0.rsp_dr), 64'(exp_dr));
    check({tag, "_rsp_ir_out"}, 64'(bus0.rsp_ir_out), 64'(exp_ir));
    check({tag, "_slave_tdi"},  64'(tdi_seen0), 64'(dr));
    check({tag, "_sdr_rises"},  64'(sidx0), 64'(DRW));
  endtask

  typedef struct {
    logic [1:0]     ir;
    logic [DRW-1:0] dr;
    logic [DRW-1:0] tdo;
    logic [1:0]     irout;
    logic [DRW-1:0] exp_dr;
    logic [1:0]     exp_ir;
    int             exp_rv;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rvcnt, rdyerr, rv1, ferr1, terr1;
    logic [DRW-1:0] r_dr, r_tdo;
    logic [1:0] r_ir, r_io;

    // Spec-derived vectors first, then randomized ones checked by the model.
    vecs[0] = '{2'b01, 38'h15_A5A5_A5A5, 38'h2A_5A5A_5A5A, 2'b00, 38'h2A_5A5A_5A5A, 2'b00, 169};
    vecs[1] = '{2'b11, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b10, 38'h3F_FFFF_FFFF, 2'b10, 169};
    vecs[2] = '{2'b00, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 2'b01, 38'h00_0000_0001, 2'b01, 169};
    for (int i = 3; i < 6; i++) begin
      r_dr  = 38'({$urandom(), $urandom()});
      r_tdo = 38'({$urandom(), $urandom()});
      r_ir  = 2'($urandom_range(3, 0));
      r_io  = 2'($urandom_range(3, 0));
      vecs[i] = '{r_ir, r_dr, r_tdo, r_io, r_tdo, r_io, (DRW + 4) * 2 * DIV0 + 1};
    end

    bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_dr = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0;
    vji_ir_out0 = 2'b00;
    vji_ir_out1 = 2'b00;

    repeat (3) @(negedge clk);
    check_reset("reset_state");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset("after_release");

    for (int i = 0; i < 6; i++) begin
      do_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].dr, vecs[i].tdo, vecs[i].irout,
              vecs[i].exp_dr, vecs[i].exp_ir, vecs[i].exp_rv, 1'b0);
      repeat (2) @(negedge clk);
    end

    // IR handling: ir_in stays at the last command after completion.
    repeat (10) @(negedge clk);
    check("ir_in_held", 64'(vji_ir_in0), 64'(vecs[5].ir));

    // Back-to-back with cmd_valid held throughout.
    do_scan("b2b_a", 2'b10, 38'h0F_0F0F_0F0F, 38'h31_2345_6789, 2'b11,
            38'h31_2345_6789, 2'b11, 169, 1'b1);
    check("b2b_valid_and_ready", 64'({bus0.rsp_valid, bus0.cmd_ready, bus0.cmd_valid}), 64'd7);
    do_scan("b2b_b", 2'b01, 38'h2B_CDEF_0123, 38'h0A_AAAA_5555, 2'b01,
            38'h0A_AAAA_5555, 2'b01, 169, 1'b0);
    repeat (2) @(negedge clk);

    // Reset asserted mid-SDR at cycle 50.
    tdo_word0 = 38'h12_3456_789A;
    bus0.cmd_ir = 2'b10; bus0.cmd_dr = 38'h1E_DCBA_9876; bus0.cmd_valid = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) bus0.cmd_valid = 1'b0;
    end
    check("abort_in_sdr", 64'(vji_sdr0), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset("abort_reset_vals");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rvcnt = 0; rdyerr = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus0.rsp_valid !== 1'b0) rvcnt++;
      if (bus0.cmd_ready !== 1'b1) rdyerr++;
    end
    check("abort_no_rsp", 64'(rvcnt), 64'd0);
    check("abort_idle_ready", 64'(rdyerr), 64'd0);
    do_scan("post_abort", 2'b01, 38'h15_A5A5_A5A5, 38'h2A_5A5A_5A5A, 2'b10,
            38'h2A_5A5A_5A5A, 2'b10, 169, 1'b0);

    // TCK_DIV = 1 on DUT1: response in cycle 85.
    tdo_word1 = 38'h2A_5A5A_5A5A;
    check("div1_ready", 64'(bus1.cmd_ready), 64'd1);
    bus1.cmd_ir = 2'b01; bus1.cmd_dr = 38'h15_A5A5_A5A5; bus1.cmd_valid = 1'b1;
    rv1 = -1; ferr1 = 0; terr1 = 0;
    for (int k = 1; k <= 200 && rv1 < 0; k++) begin
      @(negedge clk);
      bus1.cmd_valid = 1'b0;
      if ({vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1} !== exp_flags(k, DIV1)) ferr1++;
      if (vji_tck1 !== exp_tck(k, DIV1)) terr1++;
      if (bus1.rsp_valid === 1'b1) rv1 = k;
    end
    check("div1_rsp_cycle", 64'(rv1), 64'd85);
    check("div1_flag_cycles_wrong", 64'(ferr1), 64'd0);
    check("div1_tck_cycles_wrong", 64'(terr1), 64'd0);
    check("div1_rsp_dr", 64'(bus1.rsp_dr), 64'(38'h2A_5A5A_5A5A));
    check("div1_slave_tdi", 64'(tdi_seen1), 64'(38'h15_A5A5_A5A5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios2_debug_jtag_host.md
# nios2_debug_jtag_host

Host-side driver for the Nios II debug slave's 2-bit-IR / 38-bit-DR virtual JTAG interface. Accepts one debug command (IR + DR word) per transaction and sequences the UIR, CDR, SDR, UDR and RTI virtual states with a divided TCK. It returns the 38 bits shifted out of TDO and the sampled `ir_out`. It sits in the debug subsystem and simulation harness, driving the `vji_*` nets that the debug slave wrapper otherwise receives from the JTAG hub.

## Interface
Parameters:
- `DR_WIDTH`, 38: DR scan length in bits.
- `IR_WIDTH`, 2: virtual IR width.
- `TCK_DIV`, 2: clk cycles per TCK half-period; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block is idle and can accept a command.
- `cmd_ir`  in  IR_WIDTH  virtual IR value for this scan.
- `cmd_dr`  in  DR_WIDTH  data to shift in, LSB first.
- `rsp_valid`  out  1  one-cycle pulse when a scan is complete.
- `rsp_dr`  out  DR_WIDTH  TDO bits captured during SDR; bit 0 is the first bit shifted out.
- `rsp_ir_out`  out  IR_WIDTH  `vji_ir_out` sampled during UIR.
- `vji_tck`  out  1  generated TCK.
- `vji_tdi`  out  1  serial data to the slave.
- `vji_tdo`  in  1  serial data from the slave.
- `vji_ir_in`  out  IR_WIDTH  virtual IR presented to the slave.
- `vji_ir_out`  in  IR_WIDTH  slave IR status.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual-state indicators; at most one is high at any time.

## Operation
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` with `cmd_ready`, latch `cmd_ir` into `vji_ir_in`, load `cmd_dr` into the shift register, clear the bit counter and go to UIR.
- Every non-IDLE state lasts a whole number of TCK periods. One period is 2·TCK_DIV clk cycles: TCK is low for the first half and high for the second.
- UIR, CDR, UDR and RTI each last 1 period. SDR lasts exactly DR_WIDTH periods.
- The matching `vji_*` state flag is high for the entire duration of its state.
- `vji_ir_out` is sampled into `rsp_ir_out` on the TCK rising edge inside UIR.
- SDR shifting:
  - `vji_tdi` always equals `shift[0]`.
  - At each TCK rising edge, `vji_tdo` is sampled.
  - At each TCK falling edge (period end), the shift register shifts right with the sampled bit entering the MSB.
  - After DR_WIDTH periods the register holds the captured word: bit 0 is the first TDO bit.
- The bit counter is `$clog2(DR_WIDTH+1)` bits wide. SDR exits when the counter reaches DR_WIDTH-1 at the end of a period; it never wraps.
- After RTI ends, go to IDLE:
  - `rsp_dr` ← shift register.
  - `rsp_valid` is pulsed for one cycle.
  - `cmd_ready` rises in the same cycle.
- `vji_ir_in` holds its value until the next accepted command.
- `cmd_valid` while busy is ignored. The initiator holds it, and it is accepted on return to IDLE; back-to-back commands are allowed.

## Timing
- Reset values:
  - FSM=IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_dr`=0, `rsp_ir_out`=0.
  - `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0, all state flags=0.
- Acceptance is in cycle 0. UIR starts in cycle 1.
- Scan length is (DR_WIDTH+4)·2·TCK_DIV cycles. With defaults that is 168 cycles, so `rsp_valid` is high in cycle 169 and a new command can be accepted in cycle 169.
- With `cmd_valid` held continuously, two commands are accepted 169 cycles apart (defaults).
- TCK edges occur exactly at TCK_DIV-cycle boundaries relative to state entry. TCK is 0 in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-scan: all outputs return to reset values immediately (async). No `rsp_valid` is issued for the aborted command.

## Test plan
- Loopback: the bench returns TDO from a 38-bit model register preloaded with 38'h2A_5A5A_5A5A. `cmd_ir`=2'b01, `cmd_dr`=38'h15_A5A5_A5A5. Required: `rsp_dr`=38'h2A_5A5A_5A5A, the model register ends with 38'h15_A5A5_A5A5, `rsp_valid` in cycle 169.
- State sequencing: check each flag's span with defaults.
  - UIR high for cycles 1–4.
  - CDR high for cycles 5–8.
  - SDR high for cycles 9–160.
  - UDR high for cycles 161–164.
  - RTI high for cycles 165–168.
  - Exactly one flag high at any time; TCK toggles every 2 cycles.
- IR handling: `vji_ir_out`=2'b10 during the scan and `cmd_ir`=2'b11. Required: `vji_ir_in`=2'b11 from cycle 1 and held after completion; `rsp_ir_out`=2'b10.
- Back-to-back: `cmd_valid` held with two different commands. Required: second acceptance exactly in the `rsp_valid` cycle, and both responses correct.
- Reset mid-SDR: assert `reset_n`=0 at cycle 50. Required: all outputs are immediately at reset values, no `rsp_valid`, and the next command completes normally.
- TCK_DIV=1, DR_WIDTH=38: `rsp_valid` at cycle 85 and loopback data correct.
